// File: rtl/demux_lane_scheduler_pkg.sv
// Shared constants for the lane demux scheduler: FSM state encoding,
// lane indices and default widths. Optional build macro used by the
// design: DEMUX_SCHED_STATS_EN (per-lane beat counters).
package demux_sched_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } sched_state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux_lane_scheduler_if.sv
// Bus bundle between the upstream byte source, the scheduler and the two
// downstream lanes. Beat counter signals exist only when
// DEMUX_SCHED_STATS_EN is defined.
//
// Handshake: a beat transfers on a posedge where valid_in=1 and ready_in=1.
// ready_in is combinational and only falls when both lanes are paused; a
// beat presented with ready_in=0 is not taken and raises the sticky
// drop_err. Lane outputs carry no ready: the lane FIFOs instead steer the
// scheduler through pause0/pause1, which are sampled with the beat itself.
interface demux_lane_scheduler_if import demux_sched_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
`ifdef DEMUX_SCHED_STATS_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
);

    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic              pause0;
    logic              pause1;
    logic [DATA_W-1:0] data_out0;
    logic              valid_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out1;
    logic              lane_ptr;
    logic [1:0]        state;
    logic              drop_err;
`ifdef DEMUX_SCHED_STATS_EN
    logic [CNT_W-1:0]  beat_cnt0;
    logic [CNT_W-1:0]  beat_cnt1;
`endif

    // Scheduler side
    modport slave (
        input  valid_in, data_in, pause0, pause1,
        output ready_in, data_out0, valid_out0, data_out1, valid_out1,
               lane_ptr, state, drop_err
`ifdef DEMUX_SCHED_STATS_EN
        , output beat_cnt0, beat_cnt1
`endif
    );

    // Source / lane side
    modport master (
        output valid_in, data_in, pause0, pause1,
        input  ready_in, data_out0, valid_out0, data_out1, valid_out1,
               lane_ptr, state, drop_err
`ifdef DEMUX_SCHED_STATS_EN
        , input beat_cnt0, beat_cnt1
`endif
    );

endinterface

// File: rtl/demux_lane_select.sv
// Combinational lane picker: prefer the round-robin lane, fall back to the
// other one when the preferred lane is paused. ready drops only when both
// lanes are paused, so target is meaningless exactly when ready=0.
module demux_lane_select import demux_sched_pkg::*; (
    input  logic lane_ptr_i,
    input  logic pause0_i,
    input  logic pause1_i,
    output logic target_o,
    output logic ready_o
);

    logic ptr_paused;

    // Pick the preferred lane unless it is paused
    always_comb begin
        ptr_paused = (lane_ptr_i == LANE0) ? pause0_i : pause1_i;
        target_o   = ptr_paused ? ~lane_ptr_i : lane_ptr_i;
        ready_o    = ~(pause0_i & pause1_i);
    end

endmodule

// File: rtl/demux_lane_scheduler.sv
// Round-robin 1-to-2 byte scheduler with per-lane pause and sticky drop
// detection. All lane outputs are registered (1-cycle latency).
// Optional build macro: DEMUX_SCHED_STATS_EN adds beat_cnt0/beat_cnt1.
module demux_lane_scheduler import demux_sched_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
`ifdef DEMUX_SCHED_STATS_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    demux_lane_scheduler_if.slave  bus
);

    logic              target;
    logic              ready;
    logic              accept;

    logic [DATA_W-1:0] data_out0_q, data_out0_d;
    logic [DATA_W-1:0] data_out1_q, data_out1_d;
    logic              valid_out0_q, valid_out0_d;
    logic              valid_out1_q, valid_out1_d;
    logic              lane_ptr_q, lane_ptr_d;
    logic              drop_err_q, drop_err_d;
    sched_state_e      state_q, state_d;
`ifdef DEMUX_SCHED_STATS_EN
    logic [CNT_W-1:0]  beat_cnt0_q, beat_cnt0_d;
    logic [CNT_W-1:0]  beat_cnt1_q, beat_cnt1_d;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
`endif

    demux_lane_select u_lane_select (
        .lane_ptr_i (lane_ptr_q),
        .pause0_i   (bus.pause0),
        .pause1_i   (bus.pause1),
        .target_o   (target),
        .ready_o    (ready)
    );

    assign accept       = bus.valid_in & ready;
    assign bus.ready_in = ready;

    // Datapath next state: steer an accepted beat, otherwise hold data and drop valids
    always_comb begin
        data_out0_d  = data_out0_q;
        data_out1_d  = data_out1_q;
        valid_out0_d = 1'b0;
        valid_out1_d = 1'b0;
        lane_ptr_d   = lane_ptr_q;
        drop_err_d   = drop_err_q | (bus.valid_in & ~ready);
        if (accept) begin
            // Alternate relative to the lane actually used, not the preferred one
            lane_ptr_d = ~target;
            if (target == LANE0) begin
                data_out0_d  = bus.data_in;
                valid_out0_d = 1'b1;
            end else begin
                data_out1_d  = bus.data_in;
                valid_out1_d = 1'b1;
            end
        end
`ifdef DEMUX_SCHED_STATS_EN
        beat_cnt0_d = valid_out0_d ? beat_cnt0_q + CNT_ONE : beat_cnt0_q;
        beat_cnt1_d = valid_out1_d ? beat_cnt1_q + CNT_ONE : beat_cnt1_q;
`endif
    end

    // Datapath registers; reset discards any beat sampled on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out0_q  <= '0;
            data_out1_q  <= '0;
            valid_out0_q <= 1'b0;
            valid_out1_q <= 1'b0;
            lane_ptr_q   <= LANE0;
            drop_err_q   <= 1'b0;
`ifdef DEMUX_SCHED_STATS_EN
            beat_cnt0_q  <= '0;
            beat_cnt1_q  <= '0;
`endif
        end else begin
            data_out0_q  <= data_out0_d;
            data_out1_q  <= data_out1_d;
            valid_out0_q <= valid_out0_d;
            valid_out1_q <= valid_out1_d;
            lane_ptr_q   <= lane_ptr_d;
            drop_err_q   <= drop_err_d;
`ifdef DEMUX_SCHED_STATS_EN
            beat_cnt0_q  <= beat_cnt0_d;
            beat_cnt1_q  <= beat_cnt1_d;
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: both lanes paused wins, then a transfer, else idle
    always_comb begin
        state_d = IDLE;
        if (bus.pause0 & bus.pause1) state_d = STALL;
        else if (accept)             state_d = RUN;
    end

    // FSM and datapath outputs, straight from registers
    always_comb begin
        bus.state      = state_q;
        bus.data_out0  = data_out0_q;
        bus.data_out1  = data_out1_q;
        bus.valid_out0 = valid_out0_q;
        bus.valid_out1 = valid_out1_q;
        bus.lane_ptr   = lane_ptr_q;
        bus.drop_err   = drop_err_q;
`ifdef DEMUX_SCHED_STATS_EN
        bus.beat_cnt0  = beat_cnt0_q;
        bus.beat_cnt1  = beat_cnt1_q;
`endif
    end

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Directed bench for demux_lane_scheduler. Inputs change 1 ns after each
// posedge and outputs are sampled at that same point, away from the edge.
module tb_demux_lane_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

`ifdef DEMUX_SCHED_STATS_EN
    demux_lane_scheduler_if #(.DATA_W(8), .CNT_W(8)) bus ();
    demux_lane_scheduler #(.DATA_W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    demux_lane_scheduler_if #(.DATA_W(8)) bus ();
    demux_lane_scheduler #(.DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        bus.valid_in = v;
        bus.data_in  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v0, input logic v1,
                           input logic [7:0] d0, input logic [7:0] d1);
        chk({tag, ".valid_out0"}, 32'(bus.valid_out0), 32'(v0));
        chk({tag, ".valid_out1"}, 32'(bus.valid_out1), 32'(v1));
        chk({tag, ".data_out0"},  32'(bus.data_out0),  32'(d0));
        chk({tag, ".data_out1"},  32'(bus.data_out1),  32'(d1));
    endtask

    initial begin
        logic [7:0] d0_exp, d1_exp;

        // Reset
        reset = 1'b1;
        bus.pause0 = 1'b0;
        bus.pause1 = 1'b0;
        drive(1'b0, 8'h00);
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 8'h00, 8'h00);
        chk("reset.lane_ptr", 32'(bus.lane_ptr), 32'd0);
        chk("reset.state",    32'(bus.state),    32'd0);
        chk("reset.drop_err", 32'(bus.drop_err), 32'd0);
        chk("reset.ready_in", 32'(bus.ready_in), 32'd1);
`ifdef DEMUX_SCHED_STATS_EN
        chk("reset.beat_cnt0", 32'(bus.beat_cnt0), 32'd0);
        chk("reset.beat_cnt1", 32'(bus.beat_cnt1), 32'd0);
`endif
        reset = 1'b0;

        // Alternating stream 00..07, no pause
        d0_exp = 8'h00;
        d1_exp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i));
            tick();
            if (i % 2 == 0) d0_exp = 8'(i);
            else            d1_exp = 8'(i);
            chk_out("rr", (i % 2 == 0), (i % 2 == 1), d0_exp, d1_exp);
            chk("rr.state",    32'(bus.state),    32'd1);
            chk("rr.drop_err", 32'(bus.drop_err), 32'd0);
        end
        drive(1'b0, 8'h00);
        tick();
        chk_out("rr_end", 1'b0, 1'b0, 8'h06, 8'h07);
        chk("rr_end.state",    32'(bus.state),    32'd0);
        chk("rr_end.lane_ptr", 32'(bus.lane_ptr), 32'd0);

        // Lane 1 paused: everything lands on lane 0
        bus.pause1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h10 + 8'(i));
            tick();
            chk_out("p1", 1'b1, 1'b0, 8'h10 + 8'(i), 8'h07);
        end
        chk("p1.lane_ptr", 32'(bus.lane_ptr), 32'd1);
        bus.pause1 = 1'b0;
        drive(1'b1, 8'h14);
        tick();
        chk_out("p1_release", 1'b0, 1'b1, 8'h13, 8'h14);
        chk("p1_release.lane_ptr", 32'(bus.lane_ptr), 32'd0);

        // Both paused: stall and sticky drop
        drive(1'b0, 8'h00);
        tick();
        bus.pause0 = 1'b1;
        bus.pause1 = 1'b1;
        drive(1'b1, 8'h20);
        #1;
        chk("stall.ready_in", 32'(bus.ready_in), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.state",      32'(bus.state),      32'd2);
            chk("stall.valid_out0", 32'(bus.valid_out0), 32'd0);
            chk("stall.valid_out1", 32'(bus.valid_out1), 32'd0);
            chk("stall.drop_err",   32'(bus.drop_err),   32'd1);
            chk("stall.lane_ptr",   32'(bus.lane_ptr),   32'd0);
        end
        bus.pause0 = 1'b0;
        #1;
        chk("unstall.ready_in", 32'(bus.ready_in), 32'd1);
        tick();
        chk_out("unstall", 1'b1, 1'b0, 8'h20, 8'h14);
        chk("unstall.state",    32'(bus.state),    32'd1);
        chk("unstall.drop_err", 32'(bus.drop_err), 32'd1);
        chk("unstall.lane_ptr", 32'(bus.lane_ptr), 32'd1);
        bus.pause1 = 1'b0;
        drive(1'b0, 8'h00);
        tick();
        chk("post_stall.state",    32'(bus.state),    32'd0);
        chk("post_stall.drop_err", 32'(bus.drop_err), 32'd1);

        // Reset pulse mid-stream at byte 05
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i));
            tick();
        end
        reset = 1'b1;
        drive(1'b1, 8'h05);
        tick();
        chk_out("mid_reset", 1'b0, 1'b0, 8'h00, 8'h00);
        chk("mid_reset.lane_ptr", 32'(bus.lane_ptr), 32'd0);
        chk("mid_reset.state",    32'(bus.state),    32'd0);
        chk("mid_reset.drop_err", 32'(bus.drop_err), 32'd0);
        reset = 1'b0;
        drive(1'b1, 8'h06);
        tick();
        chk_out("after_reset", 1'b1, 1'b0, 8'h06, 8'h00);
        chk("after_reset.lane_ptr", 32'(bus.lane_ptr), 32'd1);

        // Idle gap between 30 (lane 0) and 31
        drive(1'b1, 8'h2F);
        tick();
        chk_out("pre_gap", 1'b0, 1'b1, 8'h06, 8'h2F);
        drive(1'b1, 8'h30);
        tick();
        chk_out("gap_30", 1'b1, 1'b0, 8'h30, 8'h2F);
        drive(1'b0, 8'hAA);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("gap.state",    32'(bus.state),    32'd0);
            chk("gap.lane_ptr", 32'(bus.lane_ptr), 32'd1);
            chk_out("gap", 1'b0, 1'b0, 8'h30, 8'h2F);
        end
        drive(1'b1, 8'h31);
        tick();
        chk_out("gap_31", 1'b0, 1'b1, 8'h30, 8'h31);
        chk("gap_31.lane_ptr", 32'(bus.lane_ptr), 32'd0);

        // Preferred lane 0 paused in the same cycle as the beat: skip to lane 1
        bus.pause0 = 1'b1;
        drive(1'b1, 8'h40);
        tick();
        chk_out("skip0", 1'b0, 1'b1, 8'h30, 8'h40);
        chk("skip0.lane_ptr", 32'(bus.lane_ptr), 32'd0);
        bus.pause0 = 1'b0;
        drive(1'b0, 8'h00);
        tick();

`ifdef DEMUX_SCHED_STATS_EN
        // Counter wrap on lane 0 with lane 1 paused
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.pause1 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'(i));
            tick();
            if (i == 254) chk("stats.cnt0_full", 32'(bus.beat_cnt0), 32'hFF);
        end
        chk("stats.cnt0_wrap", 32'(bus.beat_cnt0), 32'h00);
        chk("stats.cnt1",      32'(bus.beat_cnt1), 32'h00);
        bus.pause1 = 1'b0;
        drive(1'b0, 8'h00);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_lane_scheduler.md
Name: demux_lane_scheduler

Overview:
- Scheduler in front of the 1-to-2 byte demux of the PCIe lane datapath. Distributes a single valid-qualified byte stream round-robin across lane 0 and lane 1.
- Honours per-lane backpressure (pause) from the downstream lane FIFOs.
- Stalls the upstream when neither lane can accept, and flags any byte lost during a stall.
- All outputs are registered: one clock from accepted input to lane output.

Parameters:
- DATA_W, 8, byte width of data_in/data_out0/data_out1.
- CNT_W, 8, width of per-lane beat counters (optional feature only).

Ports:
- clk  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in qualifier from upstream.
- data_in  input  DATA_W  upstream byte.
- ready_in  output  1  upstream may present a beat; combinational: !(pause0 & pause1).
- pause0  input  1  lane 0 downstream cannot accept.
- pause1  input  1  lane 1 downstream cannot accept.
- data_out0  output  DATA_W  lane 0 byte, registered.
- valid_out0  output  1  lane 0 qualifier, registered.
- data_out1  output  DATA_W  lane 1 byte, registered.
- valid_out1  output  1  lane 1 qualifier, registered.
- lane_ptr  output  1  round-robin pointer: preferred lane for next beat.
- state  output  2  FSM state (IDLE=0, RUN=1, STALL=2).
- drop_err  output  1  sticky: a beat was presented while ready_in=0.

Behaviour:
- Reset (synchronous, highest priority): at the next posedge all outputs go to 0 (data_out*, valid_out*, lane_ptr, drop_err, counters); state=IDLE.
  - Reset asserted mid-stream discards the beat sampled that edge.
  - First beat after reset deassertion goes to lane 0.
- Accept: accept = valid_in & ready_in.
- Lane target on accept:
  - target = lane_ptr if pause[lane_ptr]=0, else ~lane_ptr.
  - Both pauses high cannot occur on accept, because ready_in=0.
- Next edge after accept:
  - data_out[target] <= data_in; valid_out[target] <= 1; valid_out[other] <= 0.
  - lane_ptr <= ~target. Skipping a paused lane therefore still alternates relative to the lane actually used.
- No accept: both valid_out <= 0; lane_ptr holds.
- data_out* hold their last value while the matching valid is low.
- Pause sampling: pause is sampled in the same cycle as the beat. A lane pausing after a beat has been issued does not recall that beat.
- Drop: valid_in & !ready_in at a posedge -> drop_err <= 1. It stays 1 until reset. The beat is not transferred and lane_ptr holds.
- FSM, evaluated every edge, priority top to bottom:
  - pause0 & pause1 -> STALL;
  - else accept -> RUN;
  - else -> IDLE.
  - STALL->RUN is allowed in one cycle when a pause drops and valid_in=1 in the same cycle.
- Simultaneous pause change and beat: the pause values in that cycle decide the target. There is no extra latency.
- Latency: exactly 1 cycle. Throughput: 1 beat/cycle whenever at least one lane is unpaused.

Optional Feature:
- Macro DEMUX_SCHED_STATS_EN.
- Defined:
  - Adds outputs beat_cnt0 and beat_cnt1, each CNT_W wide, registered, reset to 0.
  - Each counter increments on the edge that sets the matching valid_out.
  - Counters wrap from 2^CNT_W-1 to 0 with no saturation.
- Not defined: no counter ports and no counter logic; all other behaviour is identical.

Decomposition:
- Package demux_sched_pkg holds:
  - state encoding constants IDLE/RUN/STALL (2-bit);
  - lane index constants LANE0=0, LANE1=1;
  - default DATA_W and CNT_W values.
- One sub-module is natural: demux_lane_select. It is combinational: inputs lane_ptr, pause0, pause1; outputs target and ready. It is instantiated once.
- Registers, FSM and counters stay in demux_lane_scheduler.

Test Plan:
- Bytes 0x00..0x07 on consecutive cycles, valid_in=1, no pause -> lane 0 gets 00,02,04,06 and lane 1 gets 01,03,05,07, each 1 cycle after input. Valids never overlap; state=RUN; drop_err=0.
- pause1=1 held, bytes 0x10..0x13 -> all four appear on lane 0 on consecutive cycles; valid_out1 stays 0. After pause1 drops, next byte 0x14 goes to lane 1, because lane_ptr=1 after the last lane-0 beat.
- pause0=pause1=1 for 3 cycles with valid_in=1, data 0x20 -> ready_in=0, state=STALL, no valid_out, drop_err=1 sticky. Releasing pause0 -> 0x20 accepted to lane 0 next edge and drop_err remains 1.
- reset pulsed for 1 cycle during a stream at byte 0x05 -> all outputs 0 next edge, 0x05 discarded. Next byte 0x06 goes to lane 0.
- Idle gap: valid_in=0 for 2 cycles between 0x30 (lane 0) and 0x31 -> state=IDLE during the gap, lane_ptr holds 1, 0x31 goes to lane 1.
- DEMUX_SCHED_STATS_EN defined, pause1=1, 256 beats -> beat_cnt0 reaches 0xFF and then wraps to 0x00; beat_cnt1=0.
